// File: rtl/elastic_pipeline_reg.sv
// rtl/elastic_pipeline_reg.sv - multi-stage valid/ready pipeline register with bubble collapse, flush and optional input skid
module elastic_pipeline_reg #(
    parameter int N      = 32,
    parameter int STAGES = 2,
    parameter int SKID   = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          FLUSH,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  out_data,
    output logic [$clog2(STAGES+2)-1:0]   count
);
    localparam int CW = $clog2(STAGES + 2);

    logic [STAGES-1:0] v_q, v_d;
    logic [N-1:0]      d_q [STAGES];
    logic [N-1:0]      d_d [STAGES];
    logic              sv_q, sv_d;
    logic [N-1:0]      sd_q, sd_d;
    logic [CW-1:0]     count_q, count_d;

    logic [STAGES-1:0] open_s, take_s;
    logic              open_chain, take_bit;
    logic              acc, cmp, src_valid;
    logic [N-1:0]      src_data;

    always_comb begin
        open_s     = '0;
        take_s     = '0;
        open_chain = out_ready;
        take_bit   = 1'b0;
        // Walk from the output back so each stage sees whether its successor frees up this cycle.
        for (int i = STAGES - 1; i >= 0; i--) begin
            take_bit   = v_q[i] & open_chain;
            take_s[i]  = take_bit;
            open_chain = ~v_q[i] | take_bit;
            open_s[i]  = open_chain;
        end
    end

    always_comb begin
        if (SKID != 0) begin
            in_ready  = ~sv_q & ~FLUSH & ~RST;
            acc       = in_valid & in_ready;
            src_valid = sv_q | acc;
            src_data  = sv_q ? sd_q : in_data;
        end else begin
            in_ready  = open_s[0] & ~FLUSH & ~RST;
            acc       = in_valid & in_ready;
            src_valid = acc;
            src_data  = in_data;
        end

        sv_d = sv_q;
        sd_d = sd_q;
        if (SKID != 0) begin
            if (sv_q && open_s[0]) begin
                sv_d = 1'b0;
            end else if (acc && !open_s[0]) begin
                sv_d = 1'b1;
                sd_d = in_data;
            end
        end

        v_d = v_q;
        d_d = d_q;
        if (src_valid && open_s[0]) begin
            v_d[0] = 1'b1;
            d_d[0] = src_data;
        end else if (take_s[0]) begin
            v_d[0] = 1'b0;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (take_s[i-1]) begin
                v_d[i] = 1'b1;
                d_d[i] = d_q[i-1];
            end else if (take_s[i]) begin
                v_d[i] = 1'b0;
            end
        end

        cmp     = v_q[STAGES-1] & out_ready;
        count_d = count_q + CW'(acc) - CW'(cmp);
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            v_q     <= '0;
            d_q     <= '{default: '0};
            sv_q    <= 1'b0;
            sd_q    <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            sv_q    <= sv_d;
            sd_q    <= sd_d;
            count_q <= count_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign count     = count_q;
endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// tb/tb_elastic_pipeline_reg.sv - self-checking bench: queue/position model plus directed and random stimulus
module tb_elastic_pipeline_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       fl  [2];
    logic       iv  [2];
    logic       ordy[2];
    logic [7:0] idat[2];
    logic       ir0, ov0, ir1, ov1;
    logic [7:0] od0, od1;
    logic [2:0] cnt0;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: each held beat is a (data, position) pair; position -1 is the skid, STAGES-1 the output.
    int md [2][8];
    int mp [2][8];
    int msz[2];

    elastic_pipeline_reg #(.N(8), .STAGES(3), .SKID(1)) dut_a (
        .CLK(clk), .RST(rst[0]), .FLUSH(fl[0]),
        .in_valid(iv[0]), .in_ready(ir0), .in_data(idat[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0), .count(cnt0)
    );

    elastic_pipeline_reg #(.N(8), .STAGES(1), .SKID(0)) dut_b (
        .CLK(clk), .RST(rst[1]), .FLUSH(fl[1]),
        .in_valid(iv[1]), .in_ready(ir1), .in_data(idat[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1), .count(cnt1)
    );

    function automatic int stg(int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic bit skd(int k);
        return (k == 0);
    endfunction

    // Lowest free position behind the queue tail once this cycle's moves are applied.
    function automatic int new_limit(int k);
        int lim;
        int first;
        int np;
        lim   = stg(k) - 1;
        first = 0;
        if (msz[k] > 0 && mp[k][0] == stg(k) - 1 && ordy[k]) first = 1;
        for (int j = first; j < msz[k]; j++) begin
            np  = (mp[k][j] + 1 < lim) ? mp[k][j] + 1 : lim;
            lim = np - 1;
        end
        return lim;
    endfunction

    function automatic bit m_in_ready(int k);
        if (rst[k] || fl[k]) return 1'b0;
        if (skd(k)) begin
            for (int j = 0; j < msz[k]; j++)
                if (mp[k][j] < 0) return 1'b0;
            return 1'b1;
        end
        return new_limit(k) >= 0;
    endfunction

    task automatic m_step(int k);
        bit acc;
        int lim;
        if (rst[k]) begin
            msz[k] = 0;
            return;
        end
        acc = iv[k] && m_in_ready(k);
        if (msz[k] > 0 && mp[k][0] == stg(k) - 1 && ordy[k]) begin
            for (int j = 1; j < msz[k]; j++) begin
                md[k][j-1] = md[k][j];
                mp[k][j-1] = mp[k][j];
            end
            msz[k]--;
        end
        lim = stg(k) - 1;
        for (int j = 0; j < msz[k]; j++) begin
            mp[k][j] = (mp[k][j] + 1 < lim) ? mp[k][j] + 1 : lim;
            lim      = mp[k][j] - 1;
        end
        if (acc) begin
            md[k][msz[k]] = int'(idat[k]);
            mp[k][msz[k]] = (lim < 0) ? -1 : 0;
            msz[k]++;
        end
        if (fl[k]) msz[k] = 0;
    endtask

    always @(posedge clk) begin
        m_step(0);
        m_step(1);
    end

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin : cmp_blk
                bit         e_ov;
                logic       a_ov, a_ir;
                logic [7:0] a_od;
                logic [2:0] a_cnt;
                e_ov  = (msz[k] > 0) && (mp[k][0] == stg(k) - 1);
                a_ov  = (k == 0) ? ov0 : ov1;
                a_ir  = (k == 0) ? ir0 : ir1;
                a_od  = (k == 0) ? od0 : od1;
                a_cnt = (k == 0) ? cnt0 : {1'b0, cnt1};
                check("out_valid", k, 32'(a_ov), 32'(e_ov));
                check("in_ready", k, 32'(a_ir), 32'(m_in_ready(k)));
                check("count", k, 32'(a_cnt), msz[k]);
                if (e_ov) check("out_data", k, 32'(a_od), md[k][0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst(int k);
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
    endtask

    initial begin
        int bias;
        rst  = '{1'b1, 1'b1};
        fl   = '{1'b0, 1'b0};
        iv   = '{1'b0, 1'b0};
        ordy = '{1'b0, 1'b0};
        idat = '{8'h00, 8'h00};
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 0, 32'(ov0), 0);
        check("rst_count", 0, 32'(cnt0), 0);
        check("rst_out_data", 0, 32'(od0), 0);
        check("rst_in_ready", 0, 32'(ir0), 0);
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Streaming: three-cycle latency then one beat per cycle.
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            idat[0] = 8'(c + 1);
            @(negedge clk);
            check("t1_in_ready", 0, 32'(ir0), 1);
            if (c < 3) begin
                check("t1_latency", 0, 32'(ov0), 0);
            end else begin
                check("t1_out_valid", 0, 32'(ov0), 1);
                check("t1_out_data", 0, 32'(od0), 32'(c - 2));
            end
            if (c == 5) check("t1_count", 0, 32'(cnt0), 3);
            tick();
        end
        iv[0] = 1'b0;
        repeat (5) tick();

        // Backpressure fills stages and skid.
        do_rst(0);
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idat[0] = 8'(8'hA0 + c);
            tick();
        end
        iv[0] = 1'b0;
        @(negedge clk);
        check("t2_count", 0, 32'(cnt0), 4);
        check("t2_in_ready", 0, 32'(ir0), 0);
        check("t2_out_data", 0, 32'(od0), 32'hA0);
        tick();
        @(negedge clk);
        check("t2_stable", 0, 32'(od0), 32'hA0);
        tick();
        ordy[0] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check("t2_drain_valid", 0, 32'(ov0), 1);
            check("t2_drain_data", 0, 32'(od0), 32'(8'hA0 + r));
            if (r == 0) check("t2_ready_skid", 0, 32'(ir0), 0);
            if (r == 1) check("t2_ready_back", 0, 32'(ir0), 1);
            tick();
        end
        @(negedge clk);
        check("t2_empty", 0, 32'(ov0), 0);
        tick();

        // Bubble collapse under stall.
        do_rst(0);
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        idat[0] = 8'h11;
        tick();
        iv[0] = 1'b0;
        repeat (2) tick();
        iv[0]   = 1'b1;
        idat[0] = 8'h22;
        tick();
        iv[0] = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("t3_count", 0, 32'(cnt0), 2);
        check("t3_in_ready", 0, 32'(ir0), 1);
        check("t3_out_data", 0, 32'(od0), 32'h11);
        tick();

        // Flush with an output handshake in the flush cycle.
        do_rst(0);
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idat[0] = 8'(8'h31 + c);
            tick();
        end
        iv[0] = 1'b0;
        fl[0] = 1'b1;
        @(negedge clk);
        check("t4_head_valid", 0, 32'(ov0), 1);
        check("t4_head_data", 0, 32'(od0), 32'h31);
        check("t4_in_ready", 0, 32'(ir0), 0);
        tick();
        fl[0]   = 1'b0;
        iv[0]   = 1'b1;
        idat[0] = 8'h40;
        @(negedge clk);
        check("t4_out_valid", 0, 32'(ov0), 0);
        check("t4_count", 0, 32'(cnt0), 0);
        check("t4_out_data", 0, 32'(od0), 0);
        check("t4_accept", 0, 32'(ir0), 1);
        tick();
        iv[0] = 1'b0;
        repeat (4) tick();

        // Reset while full.
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idat[0] = 8'(8'h61 + c);
            tick();
        end
        iv[0] = 1'b0;
        @(negedge clk);
        check("t5_full", 0, 32'(cnt0), 4);
        tick();
        rst[0] = 1'b1;
        @(negedge clk);
        check("t5_ready_in_rst", 0, 32'(ir0), 0);
        tick();
        rst[0] = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 0, 32'(ov0), 0);
        check("t5_count", 0, 32'(cnt0), 0);
        check("t5_out_data", 0, 32'(od0), 0);
        check("t5_ready_after", 0, 32'(ir0), 1);
        tick();

        // Single stage, no skid: full stage passes one beat per cycle.
        ordy[1] = 1'b1;
        iv[1]   = 1'b1;
        idat[1] = 8'h50;
        tick();
        for (int c = 1; c < 6; c++) begin
            idat[1] = 8'(8'h50 + c);
            @(negedge clk);
            check("t6_in_ready", 1, 32'(ir1), 1);
            check("t6_out_valid", 1, 32'(ov1), 1);
            check("t6_out_data", 1, 32'(od1), 32'(8'h50 + c - 1));
            tick();
        end
        iv[1] = 1'b0;
        tick();

        // Random traffic on both configurations.
        bias = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) bias = $urandom_range(1, 7);
            for (int k = 0; k < 2; k++) begin
                rst[k]  = ($urandom_range(0, 149) == 0);
                fl[k]   = ($urandom_range(0, 39) == 0);
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 7) < bias);
                idat[k] = 8'($urandom);
            end
            tick();
        end
        rst  = '{1'b0, 1'b0};
        fl   = '{1'b0, 1'b0};
        iv   = '{1'b0, 1'b0};
        ordy = '{1'b1, 1'b1};
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elastic_pipeline_reg.md
Name: elastic_pipeline_reg

Overview:
Parametrised multi-stage pipeline register with a valid/ready handshake, bubble collapsing, flush, and an optional input skid buffer.
It generalises the single enable/flush stage register. Each stage advances independently, so back-pressure stalls only the stages that must stall. The skid buffer registers the upstream ready.
It sits between CPU pipeline sections, for example IF→ID or a multi-cycle EX→MEM path.

Parameters:
- N, 32, data width per entry.
- STAGES, 2, number of pipeline stages; legal range 1..8.
- SKID, 1, 1 = insert a one-entry skid buffer at the input so in_ready has no combinational path from out_ready; 0 = no skid.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- FLUSH  input  1  synchronous clear of all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  block accepts data this cycle.
- in_data  input  N  upstream data.
- out_valid  output  1  final stage holds valid data.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  N  final stage data.
- count  output  $clog2(STAGES+2)  number of valid entries held, including the skid entry.

Behaviour:
- Reset:
  - Reset is synchronous and active-high on RST.
  - On reset, all stage valids, the skid valid, all data registers and count go to 0. out_valid=0 and out_data=0.
  - in_ready=0 while RST is high.
- State:
  - Stages 0..STAGES-1 each hold a valid bit v[i] and data d[i]. Stage STAGES-1 drives out_valid/out_data directly from registers.
  - The skid holds sv and sd; it is present only when SKID=1.
- Advance rules (combinational, evaluated each cycle):
  - take[last] = v[last] & out_ready.
  - take[i] = v[i] & open[i+1].
  - open[i] = !v[i] | take[i].
  - When v[i] & open[i+1], stage i+1 loads d[i] and sets v[i+1]=1.
  - Otherwise, if take[i+1] is true, v[i+1] clears; if not, stage i+1 holds.
  - Bubbles collapse: an empty stage always accepts from the stage before it, even while downstream is stalled.
- Input side, SKID=0:
  - in_ready = open[0] & !FLUSH.
  - An accepted beat (in_valid & in_ready) loads stage 0.
- Input side, SKID=1:
  - in_ready = !sv & !FLUSH. This is registered state plus FLUSH only.
  - Stage 0 source priority: skid first (if sv), otherwise the input.
  - If the skid is empty and open[0], an accepted beat goes directly to stage 0 (skid bypass, no added latency).
  - If the skid is empty and !open[0], an accepted beat goes into the skid (sv←1).
  - If sv & open[0], the skid drains into stage 0 (sv←0). in_ready is 0 that cycle, so no beat arrives simultaneously.
- Latency:
  - A beat accepted in cycle t into an empty pipeline has out_valid=1 in cycle t+STAGES, for both SKID values.
  - Throughput is 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO order; no beat is ever dropped or duplicated except by FLUSH.
- FLUSH:
  - FLUSH has priority over all loads.
  - On the next edge, all v[i], sv and count clear, and data registers go to 0.
  - An output handshake (out_valid & out_ready) in the flush cycle completes normally; that beat is consumed.
  - in_ready is forced to 0 during FLUSH, so no input is accepted.
  - FLUSH and RST together behave as RST.
- count:
  - Registered.
  - count_next = count + accepted_in − completed_out, or 0 on flush/reset.
  - Never exceeds STAGES+SKID.
- Full condition:
  - All v[i]=1, sv=1 (if SKID=1), and out_ready=0.
  - In this state in_ready=0 and every register holds.
- Reset mid-transfer: all held beats are discarded; no output handshake is generated in the reset cycle (out_valid is already 0 after the edge).
- Stability: out_data is stable while out_valid=1 and out_ready=0.

Test Plan:
1. Config N=8, STAGES=3, SKID=1 throughout. Streaming: RST pulse, then in_valid=1 with data 0x01,0x02,… and out_ready=1 → first out_valid at cycle +3 with 0x01, then one beat/cycle in order; in_ready stays 1; count reaches 3.
2. Backpressure: fill with 0xA0..0xA3, out_ready=0 → entries 0xA0..0xA2 sit in the stages and 0xA3 in the skid; count=4; in_ready=0; out_data stays 0xA0. Release out_ready → outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; in_ready returns to 1 one cycle after the skid drains.
3. Bubble collapse: send 0x11, idle 2 cycles, send 0x22, with out_ready=0 → both beats advance to the last two stages; count=2; in_ready=1.
4. Flush: pipeline holds 3 beats with out_ready=1; assert FLUSH for 1 cycle → the head beat is consumed that cycle, in_ready=0; next cycle out_valid=0, count=0; new input is accepted the cycle after.
5. Reset mid-operation: with count=4, assert RST → next cycle out_valid=0, count=0, out_data=0x00; in_ready=0 while RST=1 and 1 after release.
6. SKID=0, STAGES=1 variant: full stage with out_ready=1 and in_valid=1 → in_ready=1 the same cycle; one beat is accepted and one beat is output per cycle with no stall.
